// File: rtl/conv_acc_pkg.sv
// ============================================================================
//  Module      : conv_acc_pkg
//  Description : Shared types and defaults for the convolution accumulator
//                sequencer (state encoding, job descriptor, default sizes).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package conv_acc_pkg;

  localparam int unsigned AW_DEF  = 11;
  localparam int unsigned KN_DEF  = 9;
  localparam int unsigned LAT_DEF = 3;

  // Sequencer states; the controller mirrors these encodings in its localparams
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Latched layer-tile job descriptor (addresses held at the default width)
  typedef struct packed {
    logic [AW_DEF-1:0] base1;
    logic [AW_DEF-1:0] base2;
    logic [7:0]        size;
    logic [7:0]        tiles;
  } desc_t;

endpackage

`default_nettype wire

// File: rtl/conv_acc_ctrl_if.sv
// ============================================================================
//  Module      : conv_acc_ctrl_if
//  Description : Job descriptor, systolic-array handshake and accumulator
//                command bundle for conv_acc_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface conv_acc_ctrl_if
  import conv_acc_pkg::*;
#(
  parameter int AW = AW_DEF
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [AW-1:0] cfg_base1;
  logic [AW-1:0] cfg_base2;
  logic [7:0]    cfg_size;
  logic [7:0]    cfg_tiles;
  logic          abort;
  logic          pe_valid;
  logic          pe_ack;
  logic          start;
  logic [AW-1:0] base1;
  logic [AW-1:0] base2;
  logic [7:0]    size;
  logic          first_k;
  logic          last_k;
  logic          busy;
  logic          done;

  modport master (
    output cfg_valid, cfg_base1, cfg_base2, cfg_size, cfg_tiles, abort, pe_valid,
    input  cfg_ready, pe_ack, start, base1, base2, size, first_k, last_k, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_base1, cfg_base2, cfg_size, cfg_tiles, abort, pe_valid,
    output cfg_ready, pe_ack, start, base1, base2, size, first_k, last_k, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/conv_acc_ctrl.sv
// ============================================================================
//  Module      : conv_acc_ctrl
//  Description : Convolution accumulator sequencer. Walks KN kernel taps per
//                output tile, issuing one accumulator start per tap and
//                holding off until that block and the pipeline drain finish.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv_acc_ctrl
  import conv_acc_pkg::*;
#(
  parameter int AW  = AW_DEF,
  parameter int KN  = KN_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  conv_acc_ctrl_if.slave bus
);

  localparam int TW = (KN > 1) ? $clog2(KN) : 1;

  localparam logic [2:0]    c_st_idle  = 3'(ST_IDLE);
  localparam logic [2:0]    c_st_wait  = 3'(ST_WAIT);
  localparam logic [2:0]    c_st_issue = 3'(ST_ISSUE);
  localparam logic [2:0]    c_st_run   = 3'(ST_RUN);
  localparam logic [2:0]    c_st_done  = 3'(ST_DONE);
  localparam logic [TW-1:0] c_last_tap = TW'(KN - 1);
  localparam logic [8:0]    c_drain    = 9'(LAT);

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  desc_t         r_desc;
  logic [TW-1:0] r_tap;
  logic [7:0]    r_tile;
  logic [8:0]    r_cnt;
  logic [AW-1:0] r_off1;
  logic [AW-1:0] r_off2;

  logic          r_cfg_ready;
  logic          r_busy;
  logic          r_done;
  logic          r_start;
  logic [AW-1:0] r_base1;
  logic [AW-1:0] r_base2;
  logic [7:0]    r_size;
  logic          r_first_k;
  logic          r_last_k;

  logic w_accept;
  logic w_empty;
  logic w_last_tap;
  logic w_last_tile;
  logic w_run_end;

  assign w_accept    = (r_state == c_st_idle) && r_cfg_ready && bus.cfg_valid && !bus.abort;
  assign w_empty     = (r_desc.size == 8'd0) || (r_desc.tiles == 8'd0);
  assign w_last_tap  = (r_tap == c_last_tap);
  assign w_last_tile = (r_tile == (r_desc.tiles - 8'd1));
  assign w_run_end   = (r_cnt == 9'd0);

  // Next-state decode; a degenerate job is caught in WAIT from the latched descriptor
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_st_idle:  if (w_accept) w_next = c_st_wait;
      c_st_wait: begin
        if (w_empty)           w_next = c_st_done;
        else if (bus.pe_valid) w_next = c_st_issue;
      end
      c_st_issue: w_next = c_st_run;
      c_st_run: begin
        if (w_run_end) w_next = (w_last_tap && w_last_tile) ? c_st_done : c_st_wait;
      end
      c_st_done:  w_next = c_st_idle;
      default:    w_next = c_st_idle;
    endcase
    if (bus.abort) w_next = c_st_idle;
  end

  // State register and status strobes, all registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_st_idle;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_start     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cfg_ready <= (w_next == c_st_idle);
      r_busy      <= (w_next != c_st_idle);
      r_start     <= (w_next == c_st_issue);
      r_done      <= (w_next == c_st_done);
    end
  end

  // Descriptor latch, tap/tile walk, running address offsets and block outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_desc    <= '0;
      r_tap     <= '0;
      r_tile    <= '0;
      r_cnt     <= '0;
      r_off1    <= '0;
      r_off2    <= '0;
      r_base1   <= '0;
      r_base2   <= '0;
      r_size    <= '0;
      r_first_k <= 1'b0;
      r_last_k  <= 1'b0;
    end else if (bus.abort) begin
      r_tap  <= '0;
      r_tile <= '0;
      r_cnt  <= '0;
      r_off1 <= '0;
      r_off2 <= '0;
    end else begin
      case (r_state)
        c_st_idle: begin
          if (w_accept) begin
            r_desc.base1 <= AW_DEF'(bus.cfg_base1);
            r_desc.base2 <= AW_DEF'(bus.cfg_base2);
            r_desc.size  <= bus.cfg_size;
            r_desc.tiles <= bus.cfg_tiles;
            r_size       <= bus.cfg_size;
            r_tap        <= '0;
            r_tile       <= '0;
            r_off1       <= '0;
            r_off2       <= '0;
          end
        end
        c_st_wait: begin
          if (w_next == c_st_issue) begin
            r_base1   <= AW'(r_desc.base1) + r_off1;
            r_base2   <= AW'(r_desc.base2) + r_off2;
            r_first_k <= (r_tap == '0);
            r_last_k  <= w_last_tap;
          end
        end
        c_st_issue: r_cnt <= {1'b0, r_desc.size} + c_drain - 9'd1;
        c_st_run: begin
          if (!w_run_end) begin
            r_cnt <= r_cnt - 9'd1;
          end else if (w_next == c_st_wait) begin
            if (w_last_tap) begin
              r_tap  <= '0;
              r_tile <= r_tile + 8'd1;
              r_off1 <= '0;
              r_off2 <= r_off2 + AW'(r_desc.size);
            end else begin
              r_tap  <= r_tap + TW'(1);
              r_off1 <= r_off1 + AW'(r_desc.size);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.cfg_ready = r_cfg_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.start     = r_start;
  assign bus.pe_ack    = r_start;
  assign bus.base1     = r_base1;
  assign bus.base2     = r_base2;
  assign bus.size      = r_size;
  assign bus.first_k   = r_first_k;
  assign bus.last_k    = r_last_k;

endmodule

`default_nettype wire
